cordic_vectoring_mode: RTL

//  Vectoring-mode CORDIC stage for the QR-CORDIC datapath. Drives (ori_X,ori_Y) onto the +X axis in 8 micro-rotations, two per cycle.

---
 rtl/cordic_vectoring_mode.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cordic_vectoring_mode.sv
// Vectoring-mode CORDIC: rotates (ori_X, ori_Y) onto +X in 8 micro-rotations, two per cycle.
// Optional 180-degree input pre-rotation is enabled by defining VEC_QUAD_CORR_EN.
module cordic_vectoring_mode #(
  parameter logic [9:0] K = 10'b1001101110
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] ori_X,
  input  logic [12:0] ori_Y,
  output logic [12:0] vec_X,
  output logic [7:0]  sign_d,
  output logic        flip,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXE  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic        [2:0]  iter_r;
  logic signed [12:0] cal_x_r, cal_y_r;
  logic        [12:0] vec_x_r;
  logic        [7:0]  sign_d_r;
  logic               flip_r;
  logic               done_r;

  logic               d0_s, d1_s;
  logic signed [12:0] xs0_s, ys0_s, xs1_s, ys1_s;
  logic signed [13:0] sum_x0_s, sum_y0_s, sum_x1_s, sum_y1_s;
  logic signed [12:0] x1_s, y1_s, x2_s, y2_s;
  logic signed [24:0] prod_s;

  // Drops bit 12 of the 14-bit sum so this stage matches the rotation stage bit for bit.
  function automatic logic signed [12:0] trunc13(input logic signed [13:0] s);
    return {s[13], s[11:0]};
  endfunction

  // Even micro-rotation from the registers, then odd micro-rotation on its truncated result.
  always_comb begin
    d0_s  = cal_y_r[12];
    xs0_s = cal_x_r >>> iter_r;
    ys0_s = cal_y_r >>> iter_r;
    if (d0_s) begin
      sum_x0_s = {cal_x_r[12], cal_x_r} - {ys0_s[12], ys0_s};
      sum_y0_s = {cal_y_r[12], cal_y_r} + {xs0_s[12], xs0_s};
    end else begin
      sum_x0_s = {cal_x_r[12], cal_x_r} + {ys0_s[12], ys0_s};
      sum_y0_s = {cal_y_r[12], cal_y_r} - {xs0_s[12], xs0_s};
    end
    x1_s  = trunc13(sum_x0_s);
    y1_s  = trunc13(sum_y0_s);
    d1_s  = y1_s[12];
    xs1_s = x1_s >>> (iter_r + 3'd1);
    ys1_s = y1_s >>> (iter_r + 3'd1);
    if (d1_s) begin
      sum_x1_s = {x1_s[12], x1_s} - {ys1_s[12], ys1_s};
      sum_y1_s = {y1_s[12], y1_s} + {xs1_s[12], xs1_s};
    end else begin
      sum_x1_s = {x1_s[12], x1_s} + {ys1_s[12], ys1_s};
      sum_y1_s = {y1_s[12], y1_s} - {xs1_s[12], xs1_s};
    end
    x2_s   = trunc13(sum_x1_s);
    y2_s   = trunc13(sum_y1_s);
    prod_s = $signed({{12{x2_s[12]}}, x2_s}) * $signed({15'd0, K});
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = EXE;
        else       state_s = IDLE;
      end
      EXE: begin
        if (iter_r == 3'd6) state_s = DONE;
        else                state_s = EXE;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      iter_r   <= 3'd0;
      cal_x_r  <= 13'sd0;
      cal_y_r  <= 13'sd0;
      vec_x_r  <= 13'd0;
      sign_d_r <= 8'd0;
      flip_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          iter_r  <= 3'd0;
          done_r  <= 1'b0;
          cal_x_r <= $signed(ori_X);
          cal_y_r <= $signed(ori_Y);
          if (start) begin
            vec_x_r  <= 13'd0;
            sign_d_r <= 8'd0;
`ifdef VEC_QUAD_CORR_EN
            // Left half-plane inputs are pre-rotated by 180 degrees.
            if (ori_X[12]) begin
              cal_x_r <= -$signed(ori_X);
              cal_y_r <= -$signed(ori_Y);
              flip_r  <= 1'b1;
            end else begin
              flip_r  <= 1'b0;
            end
`else
            flip_r   <= 1'b0;
`endif
          end
        end
        EXE: begin
          cal_x_r                    <= x2_s;
          cal_y_r                    <= y2_s;
          sign_d_r[iter_r]           <= d0_s;
          sign_d_r[iter_r + 3'd1]    <= d1_s;
          if (iter_r == 3'd6) begin
            iter_r  <= 3'd0;
            vec_x_r <= {prod_s[24], prod_s[21:10]};
            done_r  <= 1'b1;
          end else begin
            iter_r  <= iter_r + 3'd2;
          end
        end
        DONE: begin
          iter_r <= 3'd0;
          done_r <= 1'b0;
        end
        default: begin
          iter_r <= 3'd0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign vec_X  = vec_x_r;
  assign sign_d = sign_d_r;
  assign flip   = flip_r;
  assign done   = done_r;

endmodule
